// File: rtl/lfsr_operand_gen.sv
// rtl/lfsr_operand_gen.sv - Galois-LFSR operand-pair generator with run/stop control
module lfsr_operand_gen #(
    parameter int                  OP_W      = 8,
    parameter logic [2*OP_W-1:0]   TAPS      = 16'h002D,
    parameter logic [2*OP_W-1:0]   SEED      = 16'h8000,
    parameter int                  NUM_PAIRS = 0,
    parameter int                  CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_to_generator,
    input  logic               start,
    input  logic               abort,
    input  logic               load,
    input  logic [2*OP_W-1:0]  seed_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    x,
    output logic [OP_W-1:0]    y,
    output logic [CNT_W-1:0]   pair_count,
    output logic               done
);

    localparam int LW = 2 * OP_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [LW-1:0]   lfsr;
    logic [LW-1:0]   lfsr_adv;
    logic            accept;

    assign lfsr_adv = {lfsr[LW-2:0], 1'b0} ^ (lfsr[LW-1] ? TAPS : '0);
    assign accept   = out_valid && out_ready;

    assign x = lfsr[LW-1:OP_W];
    assign y = lfsr[OP_W-1:0];

    always_ff @(posedge clk or posedge reset_to_generator) begin
        if (reset_to_generator) begin
            state      <= IDLE;
            lfsr       <= SEED;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            pair_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    // abort freezes both the LFSR and the count, even if a beat is offered
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        lfsr       <= lfsr_adv;
                        pair_count <= pair_count + CNT_W'(1);
                        if (NUM_PAIRS != 0 && pair_count == LAST_IDX) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (load) begin
                        lfsr <= (seed_in == '0) ? SEED : seed_in;
                    end
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state      <= RUN;
                        out_valid  <= 1'b1;
                        done       <= 1'b0;
                        pair_count <= '0;
                    end
                end
            endcase
            // Lock-up recovery overrides any other LFSR update on this edge
            if (lfsr == '0) begin
                lfsr <= SEED;
            end
        end
    end

endmodule
